// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: multi-cycle controller for the RV32I program-counter path.
// Fetches at PcIn, hands the instruction to decode, waits for execute, then
// pulses PcWe for one cycle with the PC adder selects held. Misaligned
// redirects, fetch timeouts and ebreak/ecall end in a sticky HALT.
module pc_fetch_sequencer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Stop,
  input  logic [31:0]      PcIn,
  output logic             ImemReq,
  output logic [31:0]      ImemAddr,
  input  logic             ImemAck,
  input  logic [31:0]      ImemRdata,
  output logic             InstrValid,
  output logic [31:0]      Instr,
  input  logic             ExDone,
  input  logic             Branch,
  input  logic             Jal,
  input  logic             Jalr,
  input  logic             ExHalt,
  input  logic [31:0]      Imm,
  input  logic [31:0]      Rs1,
  output logic             PCAsrc,
  output logic             PCBsrc,
  output logic             PcWe,
  output logic [31:0]      NextPc,
  output logic [CNT_W-1:0] RetireCnt,
  output logic             Halted,
  output logic [1:0]       Fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
  localparam logic [1:0] FAULT_ALIGN   = 2'b10;

  // Timer only needs to count up to ACK_TIMEOUT-1; when the timeout is
  // disabled it may wrap freely since nothing looks at it.
  localparam int          TW     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam bit          TO_EN  = (ACK_TIMEOUT != 0);
  localparam logic [TW-1:0] T_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_e           state_q,   state_d;
  logic [TW-1:0]    timer_q,   timer_d;
  logic [31:0]      instr_q,   instr_d;
  logic             pca_q,     pca_d;
  logic             pcb_q,     pcb_d;
  logic [31:0]      next_pc_q, next_pc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       fault_q,   fault_d;
  logic             ex_halt_q, ex_halt_d;

  logic             sel_a;
  logic             sel_b;
  logic [31:0]      target;

  // Redirect decode: Jalr beats Jal, which beats Branch; sums wrap mod 2^32.
  always_comb begin
    sel_a  = 1'b0;
    sel_b  = 1'b0;
    target = PcIn + 32'd4;
    if (Jalr) begin
      sel_a  = 1'b1;
      sel_b  = 1'b1;
      target = (Imm + Rs1) & ~32'd1;
    end else if (Jal || Branch) begin
      sel_a  = 1'b1;
      target = Imm + PcIn;
    end
  end

  // Next-state and register updates for the sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    instr_d   = instr_q;
    pca_d     = pca_q;
    pcb_d     = pcb_q;
    next_pc_d = next_pc_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    ex_halt_d = ex_halt_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
          timer_d = '0;
        end
      end
      S_FETCH: begin
        timer_d = timer_q + TW'(1);
        if (ImemAck) begin
          instr_d = ImemRdata;
          state_d = S_EXEC;
        end else if (TO_EN && (timer_q == T_LAST)) begin
          fault_d = FAULT_TIMEOUT;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        if (ExDone) begin
          pca_d     = sel_a;
          pcb_d     = sel_b;
          next_pc_d = target;
          ex_halt_d = ExHalt;
          if (target[1]) begin
            fault_d = FAULT_ALIGN;
            state_d = S_HALT;
          end else begin
            state_d = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ex_halt_q) begin
          state_d = S_HALT;
        end else if (Stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
          timer_d = '0;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      instr_q   <= '0;
      pca_q     <= 1'b0;
      pcb_q     <= 1'b0;
      next_pc_q <= '0;
      cnt_q     <= '0;
      fault_q   <= FAULT_NONE;
      ex_halt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      instr_q   <= instr_d;
      pca_q     <= pca_d;
      pcb_q     <= pcb_d;
      next_pc_q <= next_pc_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      ex_halt_q <= ex_halt_d;
    end
  end

  // Outputs are registers or state decodes; only ImemAddr passes PcIn through.
  assign ImemReq    = (state_q == S_FETCH);
  assign ImemAddr   = (state_q == S_FETCH) ? PcIn : 32'd0;
  assign InstrValid = (state_q == S_EXEC);
  assign Instr      = instr_q;
  assign PcWe       = (state_q == S_UPDATE);
  assign PCAsrc     = (state_q == S_UPDATE) && pca_q;
  assign PCBsrc     = (state_q == S_UPDATE) && pcb_q;
  assign NextPc     = next_pc_q;
  assign RetireCnt  = cnt_q;
  assign Halted     = (state_q == S_HALT);
  assign Fault      = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer. A second instance with a 2-bit
// retire counter shares all inputs so counter wrap can be observed quickly.
module tb_pc_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Rst, Start, Stop, ImemAck, ExDone, Branch, Jal, Jalr, ExHalt;
  logic [31:0] PcIn, ImemRdata, Imm, Rs1;

  logic        ImemReq, InstrValid, PCAsrc, PCBsrc, PcWe, Halted;
  logic [31:0] ImemAddr, Instr, NextPc, RetireCnt;
  logic [1:0]  Fault;

  logic        w_ImemReq, w_InstrValid, w_PCAsrc, w_PCBsrc, w_PcWe, w_Halted;
  logic [31:0] w_ImemAddr, w_Instr, w_NextPc;
  logic [1:0]  w_RetireCnt;
  logic [1:0]  w_Fault;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  pc_fetch_sequencer #(.ACK_TIMEOUT(16), .CNT_W(32)) u_dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .PcIn(PcIn),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemRdata(ImemRdata),
    .InstrValid(InstrValid), .Instr(Instr), .ExDone(ExDone), .Branch(Branch),
    .Jal(Jal), .Jalr(Jalr), .ExHalt(ExHalt), .Imm(Imm), .Rs1(Rs1),
    .PCAsrc(PCAsrc), .PCBsrc(PCBsrc), .PcWe(PcWe), .NextPc(NextPc),
    .RetireCnt(RetireCnt), .Halted(Halted), .Fault(Fault)
  );

  pc_fetch_sequencer #(.ACK_TIMEOUT(16), .CNT_W(2)) u_dut_w (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .PcIn(PcIn),
    .ImemReq(w_ImemReq), .ImemAddr(w_ImemAddr), .ImemAck(ImemAck), .ImemRdata(ImemRdata),
    .InstrValid(w_InstrValid), .Instr(w_Instr), .ExDone(ExDone), .Branch(Branch),
    .Jal(Jal), .Jalr(Jalr), .ExHalt(ExHalt), .Imm(Imm), .Rs1(Rs1),
    .PCAsrc(w_PCAsrc), .PCBsrc(w_PCBsrc), .PcWe(w_PcWe), .NextPc(w_NextPc),
    .RetireCnt(w_RetireCnt), .Halted(w_Halted), .Fault(w_Fault)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ex();
    ExDone = 0; Branch = 0; Jal = 0; Jalr = 0; ExHalt = 0;
    Imm = 0; Rs1 = 0; ImemAck = 0; Stop = 0; Start = 0;
  endtask

  task automatic do_reset();
    Rst = 1; tick(); Rst = 0;
  endtask

  initial begin
    Rst = 1; PcIn = 0; ImemRdata = 0;
    clear_ex();
    tick(); tick();

    // Reset state
    check("rst_req",    32'(ImemReq),    32'd0);
    check("rst_instr",  Instr,           32'd0);
    check("rst_cnt",    RetireCnt,       32'd0);
    check("rst_fault",  32'(Fault),      32'd0);
    check("rst_halt",   32'(Halted),     32'd0);
    check("rst_pcwe",   32'(PcWe),       32'd0);
    check("rst_ival",   32'(InstrValid), 32'd0);
    Rst = 0;

    // Sequential fetch: ack on 2nd FETCH cycle, no branch
    Start = 1; PcIn = 32'h0; tick(); Start = 0;
    check("f1_req",  32'(ImemReq), 32'd1);
    check("f1_addr", ImemAddr,     32'h0);
    tick();
    ImemAck = 1; ImemRdata = 32'h0000_0013; tick(); ImemAck = 0;
    check("f1_ival",  32'(InstrValid), 32'd1);
    check("f1_instr", Instr,           32'h13);
    check("f1_ereq",  32'(ImemReq),    32'd0);
    ExDone = 1; tick(); clear_ex();
    check("u1_pcwe", 32'(PcWe),   32'd1);
    check("u1_a",    32'(PCAsrc), 32'd0);
    check("u1_b",    32'(PCBsrc), 32'd0);
    check("u1_npc",  NextPc,      32'h4);
    tick();
    check("u1_cnt",  RetireCnt,     32'd1);
    check("u1_back", 32'(ImemReq),  32'd1);
    check("u1_we0",  32'(PcWe),     32'd0);

    // Jal with negative immediate
    PcIn = 32'h100; ImemAck = 1; tick(); ImemAck = 0;
    ExDone = 1; Jal = 1; Imm = 32'hFFFF_FFF0; tick(); clear_ex();
    check("jal_npc", NextPc,      32'h0000_00F0);
    check("jal_a",   32'(PCAsrc), 32'd1);
    check("jal_b",   32'(PCBsrc), 32'd0);
    tick();

    // Jalr and Jal together: Jalr wins, bit 0 cleared
    ImemAck = 1; tick(); ImemAck = 0;
    ExDone = 1; Jalr = 1; Jal = 1; Rs1 = 32'h2001; Imm = 32'h4; tick(); clear_ex();
    check("jalr_npc", NextPc,      32'h2004);
    check("jalr_a",   32'(PCAsrc), 32'd1);
    check("jalr_b",   32'(PCBsrc), 32'd1);
    tick();
    check("jalr_cnt", RetireCnt, 32'd3);

    // Stop outside UPDATE is ignored; branch then Stop in UPDATE -> IDLE
    ImemAck = 1; tick(); ImemAck = 0;
    Stop = 1; tick(); Stop = 0;
    check("stop_ign", 32'(InstrValid), 32'd1);
    PcIn = 32'h200; ExDone = 1; Branch = 1; Imm = 32'h8; tick(); clear_ex();
    check("br_npc", NextPc,      32'h208);
    check("br_a",   32'(PCAsrc), 32'd1);
    check("br_b",   32'(PCBsrc), 32'd0);
    Stop = 1; tick(); Stop = 0;
    check("stop_req",  32'(ImemReq), 32'd0);
    check("stop_we",   32'(PcWe),    32'd0);
    check("stop_cnt",  RetireCnt,    32'd4);
    check("wrap_cnt",  32'(w_RetireCnt), 32'd0);
    tick();
    check("idle_hold", 32'(ImemReq), 32'd0);

    // Ack in the 16th FETCH cycle still wins over timeout
    Start = 1; tick(); Start = 0;
    for (int i = 0; i < 15; i++) tick();
    check("to16_req", 32'(ImemReq), 32'd1);
    ImemAck = 1; tick(); ImemAck = 0;
    check("to16_ival",  32'(InstrValid), 32'd1);
    check("to16_fault", 32'(Fault),      32'd0);
    PcIn = 32'h4; ExDone = 1; tick(); clear_ex();
    tick();
    check("to_refetch", 32'(ImemReq), 32'd1);
    check("to_cnt",     RetireCnt,    32'd5);

    // No ack: HALT exactly 16 cycles after entering FETCH
    for (int i = 0; i < 15; i++) tick();
    check("to_c16_req",  32'(ImemReq), 32'd1);
    check("to_c16_halt", 32'(Halted),  32'd0);
    tick();
    check("to_halt",  32'(Halted),  32'd1);
    check("to_fault", 32'(Fault),   32'd1);
    check("to_req",   32'(ImemReq), 32'd0);
    Start = 1; tick(); Start = 0;
    check("to_sticky", 32'(Halted), 32'd1);
    do_reset();
    check("to_rst_h", 32'(Halted), 32'd0);
    check("to_rst_f", 32'(Fault),  32'd0);
    check("to_rst_c", RetireCnt,   32'd0);

    // Misaligned Jalr target -> HALT, Fault=10, no retire
    Start = 1; tick(); Start = 0;
    ImemAck = 1; tick(); ImemAck = 0;
    ExDone = 1; Jalr = 1; Rs1 = 32'h1000; Imm = 32'h2; tick(); clear_ex();
    check("mis_halt",  32'(Halted), 32'd1);
    check("mis_fault", 32'(Fault),  32'd2);
    check("mis_we",    32'(PcWe),   32'd0);
    check("mis_cnt",   RetireCnt,   32'd0);
    Start = 1; tick(); Start = 0;
    check("mis_sticky", 32'(Halted), 32'd1);
    check("mis_we2",    32'(PcWe),   32'd0);
    do_reset();

    // ExHalt: one PcWe pulse, retire, then HALT with no fault
    Start = 1; tick(); Start = 0;
    ImemAck = 1; ImemRdata = 32'h0010_0073; tick(); ImemAck = 0;
    PcIn = 32'h10; ExDone = 1; ExHalt = 1; tick(); clear_ex();
    check("eh_we",  32'(PcWe), 32'd1);
    check("eh_npc", NextPc,    32'h14);
    tick();
    check("eh_halt",  32'(Halted), 32'd1);
    check("eh_fault", 32'(Fault),  32'd0);
    check("eh_cnt",   RetireCnt,   32'd1);
    check("eh_we0",   32'(PcWe),   32'd0);
    do_reset();
    check("eh_rst_c", RetireCnt, 32'd0);

    // Reset mid-FETCH
    Start = 1; tick(); Start = 0;
    Rst = 1; tick(); Rst = 0;
    check("rf_req", 32'(ImemReq), 32'd0);
    tick();
    check("rf_idle", 32'(ImemReq), 32'd0);

    // Reset mid-EXEC clears the latched instruction
    Start = 1; tick(); Start = 0;
    ImemAck = 1; ImemRdata = 32'hDEAD_BEEF; tick(); ImemAck = 0;
    check("re_instr", Instr, 32'hDEAD_BEEF);
    Rst = 1; tick(); Rst = 0;
    check("re_ival",  32'(InstrValid), 32'd0);
    check("re_instr0", Instr,          32'd0);
    check("re_npc",    NextPc,         32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
